// File: rtl/sequenciador_pkg.sv
// Shared definitions for the melody sequencer: entry layout, FSM states, note indices.
package sequenciador_pkg;

    localparam int unsigned REST_BIT = 7;
    localparam int unsigned NOTE_MSB = 6;
    localparam int unsigned NOTE_LSB = 4;
    localparam int unsigned DUR_MSB  = 3;
    localparam int unsigned DUR_LSB  = 0;

    localparam int unsigned NOTE_W = NOTE_MSB - NOTE_LSB + 1;
    localparam int unsigned DUR_W  = DUR_MSB - DUR_LSB + 1;
    localparam int unsigned ENTRY_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        GAP   = 2'd3
    } estado_t;

    // Note indices into the gerador_notas square-wave bus
    localparam logic [NOTE_W-1:0] DO   = 3'd0;
    localparam logic [NOTE_W-1:0] RE   = 3'd1;
    localparam logic [NOTE_W-1:0] MI   = 3'd2;
    localparam logic [NOTE_W-1:0] FA   = 3'd3;
    localparam logic [NOTE_W-1:0] SOL  = 3'd4;
    localparam logic [NOTE_W-1:0] LA   = 3'd5;
    localparam logic [NOTE_W-1:0] SI   = 3'd6;
    localparam logic [NOTE_W-1:0] DO_5 = 3'd7;

endpackage

// File: rtl/contador_batidas.sv
// Cycle/beat counter: counts cycles 0..last, each wrap consumes one beat; expires on the last beat's wrap.
module contador_batidas #(
    parameter int unsigned CW = 4,
    parameter int unsigned BW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [BW-1:0] beats_i,
    input  logic [CW-1:0] last_i,
    output logic          tick_c_o,
    output logic          expire_c_o
);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [BW-1:0] beat_q, beat_d;

    assign tick_c_o   = en_i && (cyc_q == last_i);
    assign expire_c_o = tick_c_o && (beat_q == BW'(1));

    // Load wins over counting; a wrap restarts the cycle count and spends a beat
    always_comb begin
        cyc_d  = cyc_q;
        beat_d = beat_q;
        if (load_i) begin
            cyc_d  = '0;
            beat_d = beats_i;
        end else if (tick_c_o) begin
            cyc_d  = '0;
            beat_d = beat_q - BW'(1);
        end else if (en_i) begin
            cyc_d  = cyc_q + CW'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q  <= '0;
            beat_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/sequenciador_notas.sv
// Melody sequencer: plays host-written note entries through a single speaker pin.
module sequenciador_notas
    import sequenciador_pkg::*;
#(
    parameter int unsigned CLOCK       = 50000000,
    parameter int unsigned BEAT_CYCLES = CLOCK / 8,
    parameter int unsigned GAP_CYCLES  = CLOCK / 100,
    parameter int unsigned DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               notas,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic                     audio_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] step,
    output logic [2:0]               nota_atual
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned MAXC = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] fetched;

    estado_t            state_q, state_d;
    logic [AW-1:0]      step_q, step_d;
    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic               played_q, played_d;
    logic               audio_q, audio_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NOTE_W-1:0]  nota_q, nota_d;

    logic               cnt_load, cnt_en, cnt_expire, cnt_tick, end_song;
    logic [DUR_W-1:0]   cnt_beats;
    logic [CW-1:0]      cnt_last;

    assign fetched = mem_q[step_q];

    // Program memory: host writes in any state, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Shared timer; its wrap length follows the current phase
    assign cnt_last = (state_q == GAP) ? CW'(GAP_CYCLES - 1) : CW'(BEAT_CYCLES - 1);

    contador_batidas #(
        .CW (CW),
        .BW (DUR_W)
    ) u_contador (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .beats_i    (cnt_beats),
        .last_i     (cnt_last),
        .tick_c_o   (cnt_tick),
        .expire_c_o (cnt_expire)
    );

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        entry_d   = entry_q;
        played_d  = played_q;
        done_d    = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_beats = entry_q[DUR_MSB:DUR_LSB];
        end_song  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d  = FETCH;
                    step_d   = '0;
                    played_d = 1'b0;
                end
            end
            FETCH: begin
                entry_d = fetched;
                if (fetched[DUR_MSB:DUR_LSB] != '0) begin
                    state_d   = PLAY;
                    played_d  = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_beats = fetched[DUR_MSB:DUR_LSB];
                end else begin
                    end_song = 1'b1;
                end
            end
            PLAY: begin
                cnt_en = 1'b1;
                if (cnt_expire) begin
                    state_d   = GAP;
                    cnt_load  = 1'b1;
                    cnt_beats = DUR_W'(1);
                end
            end
            GAP: begin
                cnt_en = 1'b1;
                if (cnt_expire) begin
                    if (step_q != AW'(DEPTH - 1)) begin
                        step_d  = step_q + AW'(1);
                        state_d = FETCH;
                    end else begin
                        end_song = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Looping needs a playable entry since step 0, otherwise an empty song would spin
        if (end_song) begin
            step_d = '0;
            if (loop && played_q) begin
                state_d  = FETCH;
                played_d = 1'b0;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        if (stop && (state_q != IDLE)) begin
            state_d  = IDLE;
            step_d   = '0;
            done_d   = 1'b0;
            cnt_load = 1'b0;
            cnt_en   = 1'b0;
        end

        audio_d = (state_q == PLAY) && !entry_q[REST_BIT] && !stop
                  && notas[entry_q[NOTE_MSB:NOTE_LSB]];
        busy_d  = (state_d != IDLE);

        nota_d = nota_q;
        if (state_d == IDLE) begin
            nota_d = DO;
        end else if (state_q == FETCH) begin
            nota_d = fetched[NOTE_MSB:NOTE_LSB];
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            step_q   <= '0;
            entry_q  <= '0;
            played_q <= 1'b0;
            audio_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            nota_q   <= DO;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            entry_q  <= entry_d;
            played_q <= played_d;
            audio_q  <= audio_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            nota_q   <= nota_d;
        end
    end

    assign audio_out  = audio_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign step       = step_q;
    assign nota_atual = nota_q;

    logic unused_tick;
    assign unused_tick = cnt_tick;

endmodule

// File: tb/tb_sequenciador_notas.sv
// Scoreboard bench for sequenciador_notas: cycle model pushes expected outputs, checker pops and compares.
module tb_sequenciador_notas;

    localparam int unsigned BEAT  = 10;
    localparam int unsigned GAPC  = 2;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] notas;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       start, stop, loop;
    logic       audio_out, busy, done;
    logic [1:0] step;
    logic [2:0] nota_atual;

    sequenciador_notas #(
        .CLOCK       (1000),
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAPC),
        .DEPTH       (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .notas      (notas),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .audio_out  (audio_out),
        .busy       (busy),
        .done       (done),
        .step       (step),
        .nota_atual (nota_atual)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Free-running square-wave bus, changes away from the sampling edge
    logic [7:0] notas_cnt = 8'd0;
    always @(negedge clk) begin
        notas_cnt = notas_cnt + 8'd1;
        notas     = notas_cnt;
    end

    typedef struct packed {
        logic       audio;
        logic       busy;
        logic       done;
        logic [1:0] step;
        logic [2:0] nota;
    } obs_t;

    obs_t       exp_q[$];
    obs_t       m_out = '0;
    int         m_state = 0;      // 0 idle, 1 fetch, 2 play, 3 gap
    int         m_rem = 0;        // cycles left in the current play/gap
    int         m_step = 0;
    bit         m_played = 1'b0;
    logic [7:0] m_ent = 8'h00;
    logic [7:0] m_mem [4];

    // Reference model: expected registered outputs after each active edge
    always @(posedge clk) begin
        obs_t       nx;
        logic [7:0] e;
        bit         end_song;
        nx       = m_out;
        nx.done  = 1'b0;
        end_song = 1'b0;
        if (rst) begin
            m_state  = 0;
            m_step   = 0;
            m_rem    = 0;
            m_played = 1'b0;
            nx       = '0;
        end else begin
            nx.audio = (m_state == 2) && !m_ent[7] && !stop && notas[m_ent[6:4]];
            if (stop && m_state != 0) begin
                m_state = 0;
                m_step  = 0;
            end else begin
                case (m_state)
                    0: if (start && !stop) begin
                        m_state  = 1;
                        m_step   = 0;
                        m_played = 1'b0;
                    end
                    1: begin
                        e       = m_mem[m_step];
                        m_ent   = e;
                        nx.nota = e[6:4];
                        if (e[3:0] != 4'd0) begin
                            m_state  = 2;
                            m_rem    = int'(e[3:0]) * BEAT;
                            m_played = 1'b1;
                        end else begin
                            end_song = 1'b1;
                        end
                    end
                    2: begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_state = 3;
                            m_rem   = GAPC;
                        end
                    end
                    default: begin
                        m_rem--;
                        if (m_rem == 0) begin
                            if (m_step < DEPTH - 1) begin
                                m_step++;
                                m_state = 1;
                            end else begin
                                end_song = 1'b1;
                            end
                        end
                    end
                endcase
                if (end_song) begin
                    m_step = 0;
                    if (loop && m_played) begin
                        m_state  = 1;
                        m_played = 1'b0;
                    end else begin
                        m_state = 0;
                        nx.done = 1'b1;
                    end
                end
            end
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
        nx.busy = (m_state != 0);
        nx.step = 2'(m_step);
        if (m_state == 0) nx.nota = 3'd0;
        m_out = nx;
        exp_q.push_back(nx);
    end

    // Checker: compare DUT outputs against the oldest expected entry
    always @(posedge clk) begin
        obs_t ex;
        #1;
        if (exp_q.size() != 0) begin
            ex = exp_q.pop_front();
            if (chk_en) begin
                check_eq("audio_out", audio_out, ex.audio);
                check_eq("busy", busy, ex.busy);
                check_eq("done", done, ex.done);
                check_eq("step", step, ex.step);
                check_eq("nota_atual", nota_atual, ex.nota);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Cycles from the first busy cycle until done, plus audio-high cycles seen meanwhile
    task automatic wait_done(input int budget, output int cyc, output int hi);
        cyc = 0; hi = 0;
        while (done !== 1'b1 && cyc < budget) begin
            if (audio_out === 1'b1) hi++;
            @(negedge clk);
            cyc++;
        end
        check_eq("done_within_budget", done, 1);
    endtask

    task automatic wait_step(input logic [1:0] target, input int budget);
        int c;
        c = 0;
        while (step !== target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_eq("step_reached", step, target);
    endtask

    initial begin
        int cyc, hi, changes, ndone;
        logic [1:0] prev;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        tick(2);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_step", step, 0);
        rst = 1'b0;
        tick(2);

        // Single two-beat note then end marker
        wr(2'd0, 8'h12); wr(2'd1, 8'h00);
        pulse_start();
        check_eq("t1_busy_after_start", busy, 1);
        wait_done(200, cyc, hi);
        check_eq("t1_length", cyc, 24);
        check_eq("t1_busy_with_done", busy, 0);
        tick(3);

        // Three-beat rest: silent the whole time
        wr(2'd0, 8'h83);
        pulse_start();
        wait_done(200, cyc, hi);
        check_eq("t2_length", cyc, 34);
        check_eq("t2_audio_high", hi, 0);
        tick(3);

        // Looping over four entries, then release loop
        for (int i = 0; i < 4; i++) wr(2'(i), 8'h71);
        loop = 1'b1;
        pulse_start();
        prev = step; changes = 0; ndone = 0;
        repeat (120) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (step !== prev) begin
                check_eq("t3_step_seq", step, 2'(prev + 2'd1));
                changes++;
                prev = step;
            end
        end
        check_eq("t3_no_done_while_looping", ndone, 0);
        check_eq("t3_wrapped", (changes >= 8) ? 1 : 0, 1);
        loop = 1'b0;
        wait_done(80, cyc, hi);
        check_eq("t3_step_after_done", step, 0);
        tick(3);

        // End marker at step 0 with loop set must terminate
        wr(2'd0, 8'h00);
        loop = 1'b1;
        pulse_start();
        wait_done(20, cyc, hi);
        check_eq("t4_length", cyc, 1);
        tick(2);
        check_eq("t4_idle", busy, 0);
        loop = 1'b0;
        tick(2);

        // Stop during step 1, then replay from step 0
        wr(2'd0, 8'h12); wr(2'd1, 8'h13); wr(2'd2, 8'h00);
        pulse_start();
        wait_step(2'd1, 100);
        tick(5);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_eq("t5_stop_busy", busy, 0);
        check_eq("t5_stop_audio", audio_out, 0);
        check_eq("t5_stop_step", step, 0);
        check_eq("t5_stop_done", done, 0);
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check_eq("t5_no_done_after_stop", ndone, 0);
        pulse_start();
        wait_done(200, cyc, hi);
        check_eq("t5_replay_length", cyc, 57);
        tick(3);

        // Rewrite an upcoming entry mid-song, then reset mid-play
        wr(2'd0, 8'h12); wr(2'd1, 8'h00); wr(2'd2, 8'h00);
        pulse_start();
        tick(5);
        wr(2'd1, 8'h42);
        wait_step(2'd1, 100);
        tick(2);
        check_eq("t6_new_note", nota_atual, 4);
        tick(8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_audio", audio_out, 0);
        check_eq("t6_rst_step", step, 0);
        check_eq("t6_rst_nota", nota_atual, 0);
        tick(2);
        pulse_start();
        wait_done(200, cyc, hi);
        check_eq("t6_replay_length", cyc, 47);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/sequenciador_notas.md
Name: sequenciador_notas

Overview:
- Melody sequencer placed after gerador_notas. It plays a stored song through one speaker pin.
- Holds a small program memory of note entries, written by the host.
- On start, steps through the entries. For each entry it routes the selected gerador_notas square wave, or silence for a rest, to a single audio output for a set number of beats.
- Each note is followed by a short articulation gap of silence.

Parameters:
- CLOCK, 50000000: system clock frequency in Hz. Documentation and default derivation only.
- BEAT_CYCLES, 6250000: clock cycles per beat (125 ms at 50 MHz). Must be ≥1.
- GAP_CYCLES, 500000: silent cycles after every played entry (10 ms). Must be ≥1.
- DEPTH, 16: number of program entries. Power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- notas  in  8  square waves from gerador_notas. Index 0 = DO … 7 = DO_5.
- wr_en  in  1  program write strobe
- wr_addr  in  $clog2(DEPTH)  program write address
- wr_data  in  8  entry: [7] rest, [6:4] note index, [3:0] duration in beats (0 = end marker)
- start  in  1  begin playback from step 0 (level-sampled)
- stop  in  1  abort playback
- loop  in  1  restart at step 0 instead of finishing
- audio_out  out  1  speaker signal
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse on normal song completion
- step  out  $clog2(DEPTH)  index of the entry being played
- nota_atual  out  3  note index of the current entry (0 while idle)

Behaviour:
- Reset: state IDLE. audio_out, busy, done, step and nota_atual are all 0. Counters are cleared. Program memory is NOT cleared; its contents are undefined until written.
- Program memory:
  - Write-only from the host; wr_en is honoured in every state.
  - Reads happen only in FETCH.
  - A write to an entry takes effect the next time that entry is fetched. An entry already playing is unaffected.
- States: IDLE, FETCH, PLAY, GAP.
  - IDLE: if start=1 and stop=0, set step=0 and go to FETCH.
  - FETCH (exactly 1 cycle): latch mem[step] into an entry register.
    - If duration≠0: go to PLAY and load beat counter = duration and cycle counter = 0.
    - If duration=0: end of song (see End of song).
  - PLAY: lasts exactly duration×BEAT_CYCLES cycles.
    - The cycle counter counts 0..BEAT_CYCLES-1. At wrap the beat counter decrements.
    - Leave for GAP when the beat counter would reach 0.
  - GAP: lasts exactly GAP_CYCLES cycles, then advances the step.
    - If step < DEPTH-1: step+1, go to FETCH.
    - Otherwise: end of song.
- End of song:
  - loop=1 and the song has at least one playable entry since the last step 0: step=0, go to FETCH.
  - Otherwise: go to IDLE, pulse done for one cycle (coincident with busy falling), set step=0.
  - A duration-0 entry at step 0 with loop=1 therefore terminates with done. It never spins.
- Per-entry cost: 1 + duration×BEAT_CYCLES + GAP_CYCLES cycles.
- audio_out is registered: audio_out ← (state==PLAY && !rest) ? notas[idx] : 0. This is one cycle of latency from notas, and it is glitch-free.
- nota_atual is updated in FETCH and cleared in IDLE.
- stop:
  - Has priority over everything except rst.
  - In any non-IDLE state: next state IDLE, audio_out 0 next cycle, step 0, and no done pulse.
  - If stop and start are both asserted in IDLE, the block stays in IDLE.
- start while busy is ignored; there is no restart.
- loop is sampled only at the end-of-song decision.
- Counter widths: cycle counter $clog2(max(BEAT_CYCLES,GAP_CYCLES)) bits; beat counter 4 bits. No overflow is possible.

Decomposition:
- Package sequenciador_pkg holds:
  - entry field positions (REST_BIT=7, NOTE_MSB=6, NOTE_LSB=4, DUR_MSB=3, DUR_LSB=0);
  - the state encoding (IDLE, FETCH, PLAY, GAP);
  - note index constants DO=0 … DO_5=7, shared with gerador_notas users.
- One sub-module, contador_batidas: a cycle and beat down-counter with load, tick and expire outputs. It is reused for both PLAY and GAP timing.
- The FSM, program memory and output register stay in the top module.

Test Plan (BEAT_CYCLES=10, GAP_CYCLES=2, DEPTH=4, notas driven by a free-running bench pattern):
- Load [0]=0x12, [1]=0x00, then pulse start. Expect:
  - busy=1 the next cycle;
  - audio_out==notas[1] delayed one cycle, for 20 cycles;
  - then 0 for 2 cycles;
  - then one done pulse; busy drops with done; total 1+20+2+1 cycles.
- Load [0]=0x83, [1]=0x00. Expect audio_out=0 for the whole play with busy=1, nota_atual=0, and done after 1+30+2+1 cycles.
- Load all four entries 0x71 with loop=1. Expect step sequence 0,1,2,3,0,1…, no done pulse; clearing loop makes done fire after step 3.
- Load [0]=0x00 with loop=1 and pulse start. Expect done one cycle after FETCH, busy back to 0, no hang.
- Assert stop during PLAY of step 1. Expect IDLE next cycle, audio_out=0, step=0, no done. A later start replays from step 0.
- While playing step 0, write [1]=0x42. Expect step 1 to play note 4 for 2 beats. Then assert rst mid-PLAY: all outputs 0 next cycle and memory retained (replay works without reloading).
